// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the fetch PC through launch, run, branch-flush
// and halt phases, and keeps saturating active-cycle and issued-fetch counters.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] start_address_i,
  input  logic        branch_i,
  input  logic [15:0] branchloc_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic [15:0] pc_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic [1:0]  state_o,
  output logic [15:0] cycle_cnt_o,
  output logic [15:0] instr_cnt_o
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] FLUSH  = 2'b10;
  localparam logic [1:0] HALTED = 2'b11;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [15:0] pcReg;
  logic [15:0] pcNext;
  logic        validReg;
  logic        flushReg;
  logic [1:0]  flushCnt;
  logic [1:0]  flushCntNext;
  logic [15:0] cycleCnt;
  logic [15:0] instrCnt;
  logic        clearCnt;
  logic        active;
  logic        issue;

  function automatic logic [15:0] satInc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  always_comb begin
    stateNext    = state;
    pcNext       = pcReg;
    flushCntNext = flushCnt;
    clearCnt     = 1'b0;
    active       = 1'b0;
    issue        = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start_i) begin
          pcNext    = start_address_i;
          stateNext = RUN;
          clearCnt  = 1'b1;
        end
      end
      RUN: begin
        active = 1'b1;
        if (branch_i) begin
          pcNext       = branchloc_i;
          stateNext    = FLUSH;
          flushCntNext = 2'd0;
        end else if (halt_i) begin
          stateNext = HALTED;
        end else if (!stall_i) begin
          pcNext = pcReg + 16'd1;
          issue  = 1'b1;
        end
      end
      FLUSH: begin
        // Wrong-path control inputs are ignored; the slot just streams sequentially.
        active = 1'b1;
        pcNext = pcReg + 16'd1;
        if (flushCnt == 2'd1) begin
          stateNext    = RUN;
          flushCntNext = 2'd0;
        end else begin
          flushCntNext = flushCnt + 2'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcReg    <= RESET_PC;
      validReg <= 1'b0;
      flushReg <= 1'b0;
      flushCnt <= 2'd0;
      cycleCnt <= 16'd0;
      instrCnt <= 16'd0;
    end else begin
      state    <= stateNext;
      pcReg    <= pcNext;
      validReg <= (stateNext == RUN) || (stateNext == FLUSH);
      flushReg <= (stateNext == FLUSH);
      flushCnt <= flushCntNext;
      if (clearCnt) begin
        cycleCnt <= 16'd0;
        instrCnt <= 16'd0;
      end else begin
        if (active) cycleCnt <= satInc(cycleCnt);
        if (issue)  instrCnt <= satInc(instrCnt);
      end
    end
  end

  assign pc_o        = pcReg;
  assign valid_o     = validReg;
  assign flush_o     = flushReg;
  assign state_o     = state;
  assign cycle_cnt_o = cycleCnt;
  assign instr_cnt_o = instrCnt;

endmodule
